// File: rtl/world_clock_pkg.sv
// Shared types and constants for the world-clock scheduler.
// Zone indices, FSM states and sentinel values.
package world_clock_pkg;

    localparam int NZONE = 4;
    localparam logic [4:0] HOUR_INVALID = 5'd31;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    typedef logic [1:0] zone_t;

    localparam zone_t ZONE_KST = 2'd0;
    localparam zone_t ZONE_CET = 2'd1;
    localparam zone_t ZONE_EST = 2'd2;
    localparam zone_t ZONE_UTC = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_e;

endpackage

// File: rtl/world_clock_sched_if.sv
// Link between the scheduler and the combinational converter.
// master: drives conv_hour/tz_sel, reads hour24. slave: converter side.
interface world_clock_sched_if;
    logic [4:0] conv_hour;
    logic [1:0] tz_sel;
    logic [4:0] hour24;

    modport master (
        output conv_hour,
        output tz_sel,
        input  hour24
    );

    modport slave (
        input  conv_hour,
        input  tz_sel,
        output hour24
    );
endinterface

// File: rtl/world_clock_sched_zone_rotator.sv
// Displayed-zone rotator: dwell timer on tick_1hz plus button advance.
// Ports: clk, rst_n, tick_1hz, btn_next, auto_en -> disp_idx.
module zone_rotator
    import world_clock_pkg::*;
#(
    parameter int DWELL_S = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  tick_1hz,
    input  logic  btn_next,
    input  logic  auto_en,
    output zone_t disp_idx
);

    localparam logic [5:0] DWELL_LAST = 6'(DWELL_S - 1);

    logic [5:0] dwell_cnt_q;
    logic [5:0] dwell_cnt_d;
    zone_t      disp_idx_q;
    zone_t      disp_idx_d;
    logic       expire;
    logic       adv;

    // Button and expiry in the same cycle collapse into one advance.
    always_comb begin
        expire = auto_en && tick_1hz && (dwell_cnt_q == DWELL_LAST);
        adv = expire || btn_next;
        dwell_cnt_d = dwell_cnt_q;
        disp_idx_d = disp_idx_q;
        if (adv) begin
            dwell_cnt_d = '0;
            disp_idx_d = disp_idx_q + 2'd1;
        end else if (!auto_en) begin
            dwell_cnt_d = '0;
        end else if (tick_1hz) begin
            dwell_cnt_d = dwell_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt_q <= '0;
            disp_idx_q <= ZONE_KST;
        end else begin
            dwell_cnt_q <= dwell_cnt_d;
            disp_idx_q <= disp_idx_d;
        end
    end

    assign disp_idx = disp_idx_q;

endmodule

// File: rtl/world_clock_sched.sv
// Time-shares one world-time converter over four zones into a result bank.
// Ports: timekeeping inputs, converter link (conv), status, display outputs.
module world_clock_sched
    import world_clock_pkg::*;
#(
    parameter int DWELL_S = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          hour_kst,
    input  logic                refresh_req,
    input  logic                tick_1hz,
    input  logic                btn_next,
    input  logic                auto_en,
    world_clock_sched_if.master conv,
    output logic                busy,
    output logic                done,
    output logic                valid,
    output logic [1:0]          disp_idx,
    output logic [4:0]          disp_hour,
    output logic                err_range
);

    state_e     state_q;
    state_e     state_d;
    logic [4:0] conv_hour_q;
    logic [4:0] conv_hour_d;
    logic [4:0] last_hour_q;
    logic [4:0] last_hour_d;
    zone_t      tz_sel_q;
    zone_t      tz_sel_d;
    logic       pend_q;
    logic       pend_d;
    logic       valid_q;
    logic       valid_d;
    logic       err_q;
    logic       err_d;
    logic [4:0] bank_q [NZONE];
    logic [4:0] bank_d [NZONE];
    logic       hour_ok;
    logic       start;

    assign hour_ok = (hour_kst <= HOUR_MAX);
    assign start = (state_q == IDLE) && hour_ok
                && ((hour_kst != last_hour_q) || pend_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SWEEP;
            SWEEP:   if (tz_sel_q == ZONE_UTC) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SWEEP);
        done = (state_q == DONE);
    end

    // tz_sel_q doubles as the sweep index; it returns to 0 after zone 3.
    always_comb begin
        conv_hour_d = conv_hour_q;
        last_hour_d = last_hour_q;
        tz_sel_d = tz_sel_q;
        valid_d = valid_q;
        err_d = err_q;
        bank_d = bank_q;
        if (start) begin
            pend_d = 1'b0;
        end else if (refresh_req) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
        if (state_q == IDLE) begin
            if (start) begin
                conv_hour_d = hour_kst;
                last_hour_d = hour_kst;
                tz_sel_d = ZONE_KST;
            end
            if (!hour_ok) begin
                err_d = 1'b1;
            end
        end
        if (state_q == SWEEP) begin
            bank_d[tz_sel_q] = conv.hour24;
            tz_sel_d = tz_sel_q + 2'd1;
        end
        if (state_q == DONE) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_hour_q <= '0;
            last_hour_q <= HOUR_INVALID;
            tz_sel_q <= ZONE_KST;
            pend_q <= 1'b0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
            for (int i = 0; i < NZONE; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            conv_hour_q <= conv_hour_d;
            last_hour_q <= last_hour_d;
            tz_sel_q <= tz_sel_d;
            pend_q <= pend_d;
            valid_q <= valid_d;
            err_q <= err_d;
            bank_q <= bank_d;
        end
    end

    zone_rotator #(
        .DWELL_S(DWELL_S)
    ) u_rot (
        .clk(clk),
        .rst_n(rst_n),
        .tick_1hz(tick_1hz),
        .btn_next(btn_next),
        .auto_en(auto_en),
        .disp_idx(disp_idx)
    );

    assign conv.conv_hour = conv_hour_q;
    assign conv.tz_sel = tz_sel_q;
    assign valid = valid_q;
    assign err_range = err_q;
    assign disp_hour = bank_q[disp_idx];

endmodule

// File: tb/tb_world_clock_sched.sv
// Directed bench for world_clock_sched with a behavioural converter.
// Drives and samples on the falling edge.
module tb_world_clock_sched;

    logic       clk;
    logic       rst_n;
    logic [4:0] hour_kst;
    logic       refresh_req;
    logic       tick_1hz;
    logic       btn_next;
    logic       auto_en;
    logic       busy;
    logic       done;
    logic       valid;
    logic [1:0] disp_idx;
    logic [4:0] disp_hour;
    logic       err_range;

    int n_pass;
    int n_total;
    logic [1:0] exp_idx;

    world_clock_sched_if cif ();

    world_clock_sched #(
        .DWELL_S(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hour_kst(hour_kst),
        .refresh_req(refresh_req),
        .tick_1hz(tick_1hz),
        .btn_next(btn_next),
        .auto_en(auto_en),
        .conv(cif.master),
        .busy(busy),
        .done(done),
        .valid(valid),
        .disp_idx(disp_idx),
        .disp_hour(disp_hour),
        .err_range(err_range)
    );

    // Converter: KST +9, CET +1, EST -5, UTC 0.
    always_comb begin
        int h;
        h = int'(cif.conv_hour);
        case (cif.tz_sel)
            2'd0: cif.hour24 = 5'(h % 24);
            2'd1: cif.hour24 = 5'((h + 16) % 24);
            2'd2: cif.hour24 = 5'((h + 10) % 24);
            default: cif.hour24 = 5'((h + 15) % 24);
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic read_bank(output logic [3:0][4:0] b);
        for (int i = 0; i < 4; i++) begin
            b[disp_idx] = disp_hour;
            btn_next = 1'b1;
            @(negedge clk);
            btn_next = 1'b0;
        end
    endtask

    task automatic tick(input logic b);
        tick_1hz = 1'b1;
        btn_next = b;
        @(negedge clk);
        tick_1hz = 1'b0;
        btn_next = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hour_kst = 5'd10;
        refresh_req = 1'b0;
        tick_1hz = 1'b0;
        btn_next = 1'b0;
        auto_en = 1'b0;
        exp_idx = 2'd0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, done, valid, err_range} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000",
                     {busy, done, valid, err_range});
        else n_pass++;
        n_total++;
        if ({cif.conv_hour, cif.tz_sel, disp_idx, disp_hour} !== 14'd0)
            $display("FAIL reset_data got %h want 0",
                     {cif.conv_hour, cif.tz_sel, disp_idx, disp_hour});
        else n_pass++;
    endtask

    task automatic test_first_sweep();
        int cnt;
        logic [3:0][4:0] b;
        rst_n = 1'b1;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_total++;
        if (cnt !== 5) $display("FAIL first_latency got %0d want 5", cnt);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({valid, done} !== 2'b10)
            $display("FAIL first_valid got %b want 10", {valid, done});
        else n_pass++;
        read_bank(b);
        n_total++;
        if (b !== {5'd1, 5'd20, 5'd2, 5'd10})
            $display("FAIL bank_10 got %h want %h", b,
                     {5'd1, 5'd20, 5'd2, 5'd10});
        else n_pass++;
    endtask

    task automatic test_hour_change();
        int nb;
        int cnt;
        logic [3:0][4:0] b;
        hour_kst = 5'd3;
        nb = 0;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            if (busy) nb++;
            cnt++;
        end
        n_total++;
        if (nb !== 4 || cnt >= 20)
            $display("FAIL busy_len got %0d want 4", nb);
        else n_pass++;
        @(negedge clk);
        read_bank(b);
        n_total++;
        if (b !== {5'd18, 5'd13, 5'd19, 5'd3})
            $display("FAIL bank_3 got %h want %h", b,
                     {5'd18, 5'd13, 5'd19, 5'd3});
        else n_pass++;
    endtask

    task automatic test_change_mid_sweep();
        int cnt;
        int nd;
        int d1;
        int d2;
        logic [3:0][4:0] b;
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
        cnt = 0;
        while (!busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        @(negedge clk);
        hour_kst = 5'd4;
        nd = 0;
        d1 = 0;
        d2 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) begin
                    d1 = i;
                    n_total++;
                    if (cif.conv_hour !== 5'd3)
                        $display("FAIL frozen_hour got %0d want 3",
                                 cif.conv_hour);
                    else n_pass++;
                end else begin
                    d2 = i;
                end
            end
        end
        n_total++;
        if (nd !== 2 || d2 - d1 !== 6)
            $display("FAIL mid_change got %0d dones gap %0d want 2 gap 6",
                     nd, d2 - d1);
        else n_pass++;
        read_bank(b);
        n_total++;
        if (b !== {5'd19, 5'd14, 5'd20, 5'd4})
            $display("FAIL bank_4 got %h want %h", b,
                     {5'd19, 5'd14, 5'd20, 5'd4});
        else n_pass++;
    endtask

    task automatic test_refresh();
        int nd;
        int cnt;
        logic [3:0][4:0] b;
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_total++;
        if (nd !== 1) $display("FAIL refresh_idle got %0d want 1", nd);
        else n_pass++;
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
        cnt = 0;
        while (!busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_total++;
        if (nd !== 2) $display("FAIL refresh_sweep got %0d want 2", nd);
        else n_pass++;
        read_bank(b);
        n_total++;
        if (b !== {5'd19, 5'd14, 5'd20, 5'd4})
            $display("FAIL bank_refresh got %h want %h", b,
                     {5'd19, 5'd14, 5'd20, 5'd4});
        else n_pass++;
    endtask

    task automatic test_range_err();
        int nb;
        logic [3:0][4:0] b;
        hour_kst = 5'd25;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        n_total++;
        if ({err_range, nb == 0} !== 2'b11)
            $display("FAIL range got err %b busy %0d want err 1 busy 0",
                     err_range, nb);
        else n_pass++;
        hour_kst = 5'd4;
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_total++;
        if ({err_range, busy} !== 2'b10)
            $display("FAIL range_sticky got %b want 10", {err_range, busy});
        else n_pass++;
        read_bank(b);
        n_total++;
        if (b !== {5'd19, 5'd14, 5'd20, 5'd4})
            $display("FAIL bank_range got %h want %h", b,
                     {5'd19, 5'd14, 5'd20, 5'd4});
        else n_pass++;
    endtask

    task automatic test_rotation();
        auto_en = 1'b1;
        n_total++;
        if (disp_idx !== exp_idx)
            $display("FAIL rot_start got %0d want %0d", disp_idx, exp_idx);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            for (int t = 0; t < 4; t++) tick(1'b0);
            n_total++;
            if (disp_idx !== exp_idx)
                $display("FAIL rot_hold%0d got %0d want %0d",
                         j, disp_idx, exp_idx);
            else n_pass++;
            tick(1'b0);
            exp_idx = exp_idx + 2'd1;
            n_total++;
            if (disp_idx !== exp_idx)
                $display("FAIL rot_step%0d got %0d want %0d",
                         j, disp_idx, exp_idx);
            else n_pass++;
        end
    endtask

    task automatic test_btn();
        for (int t = 0; t < 4; t++) tick(1'b0);
        tick(1'b1);
        exp_idx = exp_idx + 2'd1;
        n_total++;
        if (disp_idx !== exp_idx)
            $display("FAIL btn_expiry got %0d want %0d", disp_idx, exp_idx);
        else n_pass++;
        for (int t = 0; t < 3; t++) tick(1'b0);
        auto_en = 1'b0;
        @(negedge clk);
        auto_en = 1'b1;
        for (int t = 0; t < 4; t++) tick(1'b0);
        n_total++;
        if (disp_idx !== exp_idx)
            $display("FAIL dwell_clear got %0d want %0d", disp_idx, exp_idx);
        else n_pass++;
        tick(1'b0);
        exp_idx = exp_idx + 2'd1;
        n_total++;
        if (disp_idx !== exp_idx)
            $display("FAIL dwell_after got %0d want %0d", disp_idx, exp_idx);
        else n_pass++;
        auto_en = 1'b0;
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        exp_idx = exp_idx + 2'd1;
        n_total++;
        if (disp_idx !== exp_idx)
            $display("FAIL btn_manual got %0d want %0d", disp_idx, exp_idx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        hour_kst = 5'd7;
        cnt = 0;
        while (!busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, valid, err_range, cif.tz_sel, disp_idx, disp_hour}
            !== 12'd0)
            $display("FAIL reset_mid got %h want 0",
                     {busy, valid, err_range, cif.tz_sel, disp_idx, disp_hour});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_total++;
        if (cnt !== 5) $display("FAIL rerun_latency got %0d want 5", cnt);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_first_sweep();
        test_hour_change();
        test_change_mid_sweep();
        test_refresh();
        test_range_err();
        test_rotation();
        test_btn();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
